// File: rtl/matrix_pkg.sv
// Shared types for the matrix multiplier datapath: loader FSM states,
// default element width and the row/col index width helper.
package matrix_pkg;

  localparam int unsigned DEFAULT_WIDTH_BIT = 32;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } loader_state_t;

  // Index width for a ROWSxCOLS walk: $clog2 of the larger dimension, at least 1.
  function automatic int unsigned idx_width(input int unsigned rows, input int unsigned cols);
    int unsigned m;
    m = (rows > cols) ? rows : cols;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Element stream into the matrix loader: valid/ready handshake with a frame marker.
interface matrix_stream_loader_if #(
  parameter int unsigned WIDTH_BIT = 32
);
  logic                        in_valid;
  logic signed [WIDTH_BIT-1:0] in_data;
  logic                        in_last;
  logic                        in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/matrix_load_index.sv
// Row-major row/col walker; at_end is registered from the next-state
// indices so it is valid in the same cycle as row/col.
module matrix_load_index
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3,
  localparam int unsigned CW  = idx_width(ROWS, COLS)
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          at_end
);

  logic [CW-1:0] row_n;
  logic [CW-1:0] col_n;

  // clr wins over inc; col wraps into row
  always_comb begin
    row_n = row;
    col_n = col;
    if (clr) begin
      row_n = '0;
      col_n = '0;
    end else if (inc) begin
      if (col == CW'(COLS - 1)) begin
        col_n = '0;
        row_n = (row == CW'(ROWS - 1)) ? '0 : row + CW'(1);
      end else begin
        col_n = col + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row    <= '0;
      col    <= '0;
      at_end <= (ROWS == 1) && (COLS == 1);
    end else begin
      row    <= row_n;
      col    <= col_n;
      at_end <= (row_n == CW'(ROWS - 1)) && (col_n == CW'(COLS - 1));
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Write-side front end of the matrix multiplier: assembles A then B from a
// serial element stream and holds both until the consumer releases them.
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int unsigned AROWS     = 3,
  parameter int unsigned ACOLUMNS  = 3,
  parameter int unsigned BROWS     = 3,
  parameter int unsigned BCOLUMNS  = 3,
  parameter int unsigned WIDTH_BIT = DEFAULT_WIDTH_BIT
) (
  input  logic                        clock,
  input  logic                        nreset,
  matrix_stream_loader_if.slave       stream,
  output logic signed [WIDTH_BIT-1:0] MatrixA [AROWS][ACOLUMNS],
  output logic signed [WIDTH_BIT-1:0] MatrixB [BROWS][BCOLUMNS],
  output logic                        matrices_valid,
  input  logic                        consume,
  output logic                        frame_error
);

  localparam int unsigned ACW = idx_width(AROWS, ACOLUMNS);
  localparam int unsigned BCW = idx_width(BROWS, BCOLUMNS);

  loader_state_t  state;
  loader_state_t  state_n;
  logic           xfer_c;
  logic           inc_a_c;
  logic           inc_b_c;
  logic           clr_c;
  logic           ferr_c;
  logic [ACW-1:0] a_row;
  logic [ACW-1:0] a_col;
  logic           a_at_end;
  logic [BCW-1:0] b_row;
  logic [BCW-1:0] b_col;
  logic           b_at_end;

  assign xfer_c = stream.in_valid && stream.in_ready;

  matrix_load_index #(.ROWS(AROWS), .COLS(ACOLUMNS)) u_idx_a (
    .clock  (clock),
    .nreset (nreset),
    .inc    (inc_a_c),
    .clr    (clr_c),
    .row    (a_row),
    .col    (a_col),
    .at_end (a_at_end)
  );

  matrix_load_index #(.ROWS(BROWS), .COLS(BCOLUMNS)) u_idx_b (
    .clock  (clock),
    .nreset (nreset),
    .inc    (inc_b_c),
    .clr    (clr_c),
    .row    (b_row),
    .col    (b_col),
    .at_end (b_at_end)
  );

  // Next state, index control and framing check
  always_comb begin
    state_n = state;
    inc_a_c = 1'b0;
    inc_b_c = 1'b0;
    clr_c   = 1'b0;
    ferr_c  = 1'b0;
    case (state)
      LOAD_A: begin
        if (xfer_c) begin
          if (stream.in_last) begin
            ferr_c  = 1'b1;
            clr_c   = 1'b1;
            state_n = LOAD_A;
          end else if (a_at_end) begin
            clr_c   = 1'b1;
            state_n = LOAD_B;
          end else begin
            inc_a_c = 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (xfer_c) begin
          if (b_at_end) begin
            ferr_c  = !stream.in_last;
            clr_c   = 1'b1;
            state_n = FULL;
          end else if (stream.in_last) begin
            ferr_c  = 1'b1;
            clr_c   = 1'b1;
            state_n = LOAD_A;
          end else begin
            inc_b_c = 1'b1;
          end
        end
      end
      FULL: begin
        if (consume) begin
          clr_c   = 1'b1;
          state_n = LOAD_A;
        end
      end
      default: begin
        clr_c   = 1'b1;
        state_n = LOAD_A;
      end
    endcase
  end

  // Handshake and status flops track the next state so they decode registered state
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state           <= LOAD_A;
      stream.in_ready <= 1'b1;
      matrices_valid  <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      state           <= state_n;
      stream.in_ready <= (state_n != FULL);
      matrices_valid  <= (state_n == FULL);
      frame_error     <= ferr_c;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int r = 0; r < AROWS; r++)
        for (int c = 0; c < ACOLUMNS; c++)
          MatrixA[r][c] <= '0;
    end else begin
      for (int r = 0; r < AROWS; r++)
        for (int c = 0; c < ACOLUMNS; c++)
          if (xfer_c && (state == LOAD_A) && (a_row == ACW'(r)) && (a_col == ACW'(c)))
            MatrixA[r][c] <= stream.in_data;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int r = 0; r < BROWS; r++)
        for (int c = 0; c < BCOLUMNS; c++)
          MatrixB[r][c] <= '0;
    end else begin
      for (int r = 0; r < BROWS; r++)
        for (int c = 0; c < BCOLUMNS; c++)
          if (xfer_c && (state == LOAD_B) && (b_row == BCW'(r)) && (b_col == BCW'(c)))
            MatrixB[r][c] <= stream.in_data;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: flat-position reference model checked every
// cycle, plus hand-computed expectations for each directed scenario.
module tb_matrix_stream_loader;

  logic              clock   = 1'b0;
  logic              nreset  = 1'b1;
  logic              consume = 1'b0;
  logic              matrices_valid;
  logic              frame_error;
  logic signed [31:0] mat_a [3][3];
  logic signed [31:0] mat_b [3][3];

  matrix_stream_loader_if #(.WIDTH_BIT(32)) bus ();

  matrix_stream_loader #(
    .AROWS(3), .ACOLUMNS(3), .BROWS(3), .BCOLUMNS(3), .WIDTH_BIT(32)
  ) dut (
    .clock          (clock),
    .nreset         (nreset),
    .stream         (bus),
    .MatrixA        (mat_a),
    .MatrixB        (mat_b),
    .matrices_valid (matrices_valid),
    .consume        (consume),
    .frame_error    (frame_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_mat(input string name, input logic signed [31:0] act [3][3],
                         input logic signed [31:0] exp [3][3]);
    int br;
    int bc;
    br = -1;
    bc = -1;
    checks++;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (br < 0 && act[r][c] !== exp[r][c]) begin
          br = r;
          bc = c;
        end
    if (br >= 0) begin
      errors++;
      $display("FAIL %s[%0d][%0d]: got %0d, expected %0d (t=%0t)", name, br, bc,
               act[br][bc], exp[br][bc], $time);
    end
  endtask

  // Reference model: a flat element position 0..17 plus a "matrices held" flag
  int                 pos;
  bit                 m_full;
  bit                 m_ferr;
  logic signed [31:0] ma [3][3];
  logic signed [31:0] mb [3][3];

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pos    = 0;
      m_full = 1'b0;
      m_ferr = 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          ma[r][c] = '0;
          mb[r][c] = '0;
        end
    end else begin
      m_ferr = 1'b0;
      if (m_full) begin
        if (consume) begin
          m_full = 1'b0;
          pos    = 0;
        end
      end else if (bus.in_valid) begin
        if (pos < 9) ma[pos / 3][pos % 3] = bus.in_data;
        else         mb[(pos - 9) / 3][(pos - 9) % 3] = bus.in_data;
        if (pos == 17) begin
          m_full = 1'b1;
          m_ferr = !bus.in_last;
          pos    = 0;
        end else if (bus.in_last) begin
          m_ferr = 1'b1;
          pos    = 0;
        end else begin
          pos++;
        end
      end
    end
  end

  bit cmp_en  = 1'b0;
  bit lat_run = 1'b0;
  int lat     = 0;
  int lat_seen = -1;
  int ferr_cnt = 0;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("in_ready", longint'(bus.in_ready), longint'(!m_full));
      chk("matrices_valid", longint'(matrices_valid), longint'(m_full));
      chk("frame_error", longint'(frame_error), longint'(m_ferr));
      chk_mat("MatrixA", mat_a, ma);
      chk_mat("MatrixB", mat_b, mb);
    end
    if (frame_error) ferr_cnt++;
    if (lat_run) begin
      lat++;
      if (matrices_valid) begin
        lat_run  = 1'b0;
        lat_seen = lat;
      end
    end
  end

  task automatic send(input int v, input bit last, input bit bubbles);
    @(negedge clock);
    if (bubbles) begin
      while ($urandom_range(1, 0) == 1) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clock);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'(v);
    bus.in_last  = last;
    chk("ready_at_send", longint'(bus.in_ready), 1);
    @(posedge clock);
  endtask

  task automatic send_frame(input int first, input int step, input int n,
                            input int last_at, input bit bubbles);
    for (int i = 0; i < n; i++)
      send(first + step * i, (i + 1) == last_at, bubbles);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #1;
  endtask

  task automatic release_matrices();
    @(negedge clock);
    consume = 1'b1;
    @(negedge clock);
    consume = 1'b0;
    #1;
  endtask

  int ferr_before;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #2 nreset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_valid", longint'(matrices_valid), 0);
    chk("rst_ferr", longint'(frame_error), 0);
    chk("rst_a00", longint'(mat_a[0][0]), 0);
    nreset = 1'b1;
    cmp_en = 1'b1;

    // Clean back-to-back frame 1..18
    send(1, 1'b0, 1'b0);
    lat_run = 1'b1;
    lat     = 0;
    for (int i = 2; i <= 18; i++) send(i, i == 18, 1'b0);
    idle();
    chk("latency", lat_seen, 18);
    chk("f1_valid", longint'(matrices_valid), 1);
    chk("f1_ready", longint'(bus.in_ready), 0);
    chk("f1_a00", longint'(mat_a[0][0]), 1);
    chk("f1_a12", longint'(mat_a[1][2]), 6);
    chk("f1_a22", longint'(mat_a[2][2]), 9);
    chk("f1_b00", longint'(mat_b[0][0]), 10);
    chk("f1_b20", longint'(mat_b[2][0]), 16);
    chk("f1_b22", longint'(mat_b[2][2]), 18);
    chk("f1_no_ferr", ferr_cnt, 0);

    // Held in FULL while the producer keeps offering 99
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(99);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    consume      = 1'b1;
    @(negedge clock);
    consume = 1'b0;
    #1;
    chk("consume_ready", longint'(bus.in_ready), 1);
    chk("consume_valid", longint'(matrices_valid), 0);
    chk("hold_a00", longint'(mat_a[0][0]), 1);
    chk("hold_b22", longint'(mat_b[2][2]), 18);

    // Negative frame with random bubbles
    send_frame(-1, -1, 18, 18, 1'b1);
    idle();
    chk("neg_valid", longint'(matrices_valid), 1);
    chk("neg_a00", longint'(mat_a[0][0]), -1);
    chk("neg_a11_bits", longint'(mat_a[1][1][31:0]), 64'h0000_0000_FFFF_FFFB);
    chk("neg_b22", longint'(mat_b[2][2]), -18);
    release_matrices();

    // Early in_last on element 7 resyncs to A
    ferr_before = ferr_cnt;
    send_frame(1, 1, 7, 7, 1'b0);
    idle();
    chk("early_last_ferr", longint'(frame_error), 1);
    @(negedge clock);
    #1;
    chk("early_last_ferr_drop", longint'(frame_error), 0);
    chk("early_last_once", ferr_cnt - ferr_before, 1);
    send_frame(1, 1, 18, 18, 1'b0);
    idle();
    chk("resync_valid", longint'(matrices_valid), 1);
    chk("resync_a20", longint'(mat_a[2][0]), 7);
    chk("resync_b00", longint'(mat_b[0][0]), 10);
    release_matrices();

    // Final element without in_last
    send_frame(1, 1, 18, 0, 1'b0);
    idle();
    chk("nolast_ferr", longint'(frame_error), 1);
    chk("nolast_valid", longint'(matrices_valid), 1);
    release_matrices();

    // Asynchronous reset mid-frame after 12 transfers
    send_frame(101, 1, 12, 0, 1'b0);
    #1;
    chk("pre_rst_b02", longint'(mat_b[0][2]), 112);
    #1;
    bus.in_valid = 1'b0;
    nreset       = 1'b0;
    #1;
    chk("async_a00", longint'(mat_a[0][0]), 0);
    chk("async_a22", longint'(mat_a[2][2]), 0);
    chk("async_b02", longint'(mat_b[0][2]), 0);
    chk("async_ready", longint'(bus.in_ready), 1);
    chk("async_valid", longint'(matrices_valid), 0);
    @(negedge clock);
    nreset = 1'b1;
    send_frame(201, 1, 18, 18, 1'b0);
    idle();
    chk("post_rst_a00", longint'(mat_a[0][0]), 201);
    chk("post_rst_a10", longint'(mat_a[1][0]), 204);
    chk("post_rst_b22", longint'(mat_b[2][2]), 218);
    release_matrices();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Write-side front end for the matrix multiplier. Accepts a serial stream of signed elements over a valid/ready handshake, assembles operand matrices A and B row-major in registers, and presents them in parallel with a `matrices_valid` flag. Holds both matrices stable until the downstream multiplier releases them with `consume`, then reopens for the next pair.

## Interface
- `AROWS`, default 3: rows of A.
- `ACOLUMNS`, default 3: columns of A.
- `BROWS`, default 3: rows of B. Must equal `ACOLUMNS`; not checked in RTL.
- `BCOLUMNS`, default 3: columns of B.
- `WIDTH_BIT`, default 32: element width, signed.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `nreset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` holds an element.
- `in_data`  in  signed WIDTH_BIT: element value.
- `in_last`  in  1: marks the final element of a frame (last element of B).
- `in_ready`  out  1: loader can accept an element this cycle.
- `MatrixA`  out  signed WIDTH_BIT [AROWS][ACOLUMNS]: assembled A.
- `MatrixB`  out  signed WIDTH_BIT [BROWS][BCOLUMNS]: assembled B.
- `matrices_valid`  out  1: A and B complete and stable.
- `consume`  in  1: downstream releases the matrices.
- `frame_error`  out  1: one-cycle pulse on framing violation.

## Operation
- Transfer occurs on a rising edge with `in_valid && in_ready`. No other cycle writes an element.
- FSM states: `LOAD_A`, `LOAD_B`, `FULL`.
  - `LOAD_A`: a transfer writes `MatrixA[row][col]`. `col` increments. At `ACOLUMNS-1`, `col` wraps to 0 and `row` increments. A transfer at (`AROWS-1`,`ACOLUMNS-1`) clears both counters and moves to `LOAD_B`.
  - `LOAD_B`: same scheme into `MatrixB` using `BROWS`/`BCOLUMNS`. A transfer at (`BROWS-1`,`BCOLUMNS-1`) clears the counters and moves to `FULL`.
  - `FULL`: `in_ready`=0 and `matrices_valid`=1. When `consume`=1, clears counters and moves to `LOAD_A`.
- `consume` is ignored outside `FULL`.
- `in_ready` = (state != `FULL`). It is decoded from registered state only and never depends on `in_valid`.
- Matrix registers are not cleared on `consume`. Old contents remain until each element is overwritten.
- Framing:
  - `in_last` on a transfer that is not the final B element: `frame_error` pulses, the element is still written, counters clear, and the state returns to `LOAD_A` (resync).
  - Final B element without `in_last`: `frame_error` pulses and the state still enters `FULL`.
  - `in_last` with no transfer is ignored.
- Counters are `$clog2(max dim)` bits wide (minimum 1). Stored data is `in_data` unmodified; there is no arithmetic on data.

## Timing
- Reset values:
  - state `LOAD_A`; row/col 0.
  - all `MatrixA`/`MatrixB` elements 0.
  - `in_ready`=1, `matrices_valid`=0, `frame_error`=0.
- An element is visible on `MatrixA`/`MatrixB` the cycle after its transfer edge.
- `matrices_valid` rises the cycle after the final B transfer, with full-throughput minimum AROWS·ACOLUMNS + BROWS·BCOLUMNS transfer cycles from frame start. `in_ready` falls in the same cycle.
- If `consume` is sampled high in `FULL`, the next cycle has `matrices_valid`=0 and `in_ready`=1. Minimum `FULL` dwell is 1 cycle.
- `frame_error` is registered and high for exactly the cycle after the offending transfer.
- Back-to-back transfers every cycle are supported. Bubbles (`in_valid`=0) stall counters with no effect.
- Reset asserted mid-frame returns immediately, asynchronously, to the reset values. Partial frame data is discarded by zeroing.

## Structure
- Package `matrix_pkg`: `loader_state_t` enum (`LOAD_A`, `LOAD_B`, `FULL`) and default `WIDTH_BIT`. The package is shareable with the multiplier side.
- One sub-module, `matrix_load_index`: row/col counter with parameters ROWS/COLS. Ports: inputs `clock`, `nreset`, `inc`, `clr`; outputs `row`, `col`, `at_end`. Wraps col→row, and `at_end` = (`row`==ROWS-1 && `col`==COLS-1). One instance is shared across A and B phases, with dimensions muxed by state. Two instances are also acceptable.
- Top contains the FSM, the matrix registers, framing check and handshake.

## Test plan
- Reset, then stream 1..9 (A) and 10..18 (B), `in_last` on 18, `in_valid` held high → A = [[1,2,3],[4,5,6],[7,8,9]], B = [[10..12],[13..15],[16..18]]; `matrices_valid` high 18 cycles after the first transfer edge; `in_ready` low; `frame_error` never set.
- In `FULL`, hold `in_valid`=1 with data 99 for 5 cycles, then pulse `consume` → no element changes; `in_ready`=1 and `matrices_valid`=0 the cycle after `consume`.
- Random `in_valid` bubbles (50%) on a frame of −1..−18 → same placement as an uninterrupted stream; negative values preserved bit-exact.
- `in_last` on element 7 → `frame_error` pulses once and the state returns to `LOAD_A`. A following clean frame of 1..18 loads correctly.
- Final element 18 sent without `in_last` → `frame_error` pulse coincident with `matrices_valid` rising.
- Assert `nreset` after 12 transfers → all matrix elements 0, `in_ready`=1, `matrices_valid`=0 immediately. The next frame loads from A[0][0].
